// File: rtl/pipeline_boot_ctrl_pkg.sv
// Shared definitions for the pipeline boot/run sequencer: state encoding and
// the data-path width and default instruction memory depth.
package pipeline_boot_ctrl_pkg;

    localparam int XLEN               = 32;
    localparam int IMEM_DEPTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } boot_state_e;

endpackage

// File: rtl/pipeline_boot_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory over a
// valid/ready handshake, then releases the core for a bounded or halted run.
module pipeline_boot_ctrl
    import pipeline_boot_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int CYC_W      = 16,
    parameter int ADDR_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [XLEN-1:0]   word_data,
    input  logic              word_last,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic              halt,
    output logic              start,
    output logic [XLEN-1:0]   address,
    output logic [XLEN-1:0]   instruction,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int                CNT_W    = $clog2(IMEM_DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(IMEM_DEPTH);

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              last_seen_q, last_seen_d;
    logic [CYC_W-1:0]  budget_q, budget_d;
    logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   address_q, address_d;
    logic [XLEN-1:0]   instruction_q, instruction_d;

    logic              ready_c;
    logic              beat_c;
    logic              budget_hit_c;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        if (v == {CYC_W{1'b1}}) begin
            return v;
        end
        return v + CYC_W'(1);
    endfunction

    // Once the last word is taken, ready drops so the final word is shown
    // for one cycle with start still high before the core is released.
    assign ready_c      = (state_q == ST_LOAD) && !last_seen_q && (word_cnt_q < CNT_FULL);
    assign beat_c       = word_valid && ready_c;
    assign budget_hit_c = (budget_q != '0) &&
                          (({1'b0, cycle_cnt_q} + (CYC_W + 1)'(1)) == {1'b0, budget_q});

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        last_seen_d   = last_seen_q;
        budget_d      = budget_q;
        cycle_cnt_d   = cycle_cnt_q;
        err_d         = err_q;
        address_d     = address_q;
        instruction_d = instruction_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_req) begin
                    budget_d    = run_cycles;
                    word_cnt_d  = '0;
                    last_seen_d = 1'b0;
                    cycle_cnt_d = '0;
                    err_d       = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_seen_q) begin
                    state_d = ST_RUN;
                end else if (beat_c) begin
                    address_d     = XLEN'(word_cnt_q) * XLEN'(ADDR_STEP);
                    instruction_d = word_data;
                    word_cnt_d    = word_cnt_q + CNT_W'(1);
                    last_seen_d   = word_last;
                end else if (word_cnt_q == CNT_FULL) begin
                    // Memory full without a last marker: abort, core never runs.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (halt || budget_hit_c) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            word_cnt_q    <= '0;
            last_seen_q   <= 1'b0;
            budget_q      <= '0;
            cycle_cnt_q   <= '0;
            err_q         <= 1'b0;
            address_q     <= '0;
            instruction_q <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            last_seen_q   <= last_seen_d;
            budget_q      <= budget_d;
            cycle_cnt_q   <= cycle_cnt_d;
            err_q         <= err_d;
            address_q     <= address_d;
            instruction_q <= instruction_d;
        end
    end

    assign word_ready  = ready_c;
    assign start       = (state_q != ST_RUN);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign cycle_count = cycle_cnt_q;
    assign address     = address_q;
    assign instruction = instruction_q;

endmodule

// File: tb/tb_pipeline_boot_ctrl.sv
// Scoreboard bench for pipeline_boot_ctrl: stimulus pushes expected beats,
// completion results and control-state snapshots; a monitor pops and compares.
module tb_pipeline_boot_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_last;
    logic [15:0] run_cycles;
    logic        halt;
    logic        start;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cycle_count;

    pipeline_boot_ctrl #(.IMEM_DEPTH(DEPTH), .CYC_W(16), .ADDR_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_last   (word_last),
        .run_cycles  (run_cycles),
        .halt        (halt),
        .start       (start),
        .address     (address),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;
    typedef struct { logic [15:0] cc; logic err; int runlen; } done_t;
    typedef enum { CK_RESET, CK_LOADSTART } ctl_e;

    beat_t beat_q[$];
    done_t done_q[$];
    ctl_e  ctl_q[$];

    int checks = 0;
    int errors = 0;
    bit finish_req = 1'b0;

    logic [31:0] prog [8];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: all comparisons happen on the falling edge.
    initial begin
        beat_t b;
        done_t d;
        ctl_e  c;
        bit    pend_beat = 1'b0;
        bit    done_prev = 1'b0;
        int    run_len   = 0;
        forever begin
            @(negedge clk);
            if (pend_beat) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got addr 0x%08h data 0x%08h expected no beat", address, instruction);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", address, b.addr);
                    chk("beat_data", instruction, b.data);
                    chk("beat_start", 32'(start), 32'd1);
                end
            end
            pend_beat = (word_valid === 1'b1) && (word_ready === 1'b1) && (rst === 1'b0);
            if (start === 1'b0) run_len++;
            if ((done === 1'b1) && !done_prev) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1 expected no completion");
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle_count", 32'(cycle_count), 32'(d.cc));
                    chk("done_err", 32'(err), 32'(d.err));
                    chk("done_run_len", 32'(run_len), 32'(d.runlen));
                    chk("done_busy", 32'(busy), 32'd0);
                end
                run_len = 0;
            end
            done_prev = (done === 1'b1);
            if (ctl_q.size() != 0) begin
                c = ctl_q.pop_front();
                if (c == CK_RESET) begin
                    chk("rst_start", 32'(start), 32'd1);
                    chk("rst_address", address, 32'd0);
                    chk("rst_instruction", instruction, 32'd0);
                    chk("rst_word_ready", 32'(word_ready), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_err", 32'(err), 32'd0);
                    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
                end else begin
                    chk("ld_start", 32'(start), 32'd1);
                    chk("ld_busy", 32'(busy), 32'd1);
                    chk("ld_done", 32'(done), 32'd0);
                    chk("ld_err", 32'(err), 32'd0);
                    chk("ld_cycle_count", 32'(cycle_count), 32'd0);
                    chk("ld_word_ready", 32'(word_ready), 32'd1);
                end
                run_len = 0;
            end
            if (finish_req) begin
                chk("beats_left", 32'(beat_q.size()), 32'd0);
                chk("dones_left", 32'(done_q.size()), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_load(input logic [15:0] budget);
        load_req   = 1'b1;
        run_cycles = budget;
        tick();
        load_req   = 1'b0;
        run_cycles = 16'hFFFF;
        ctl_q.push_back(CK_LOADSTART);
    endtask

    // Expectations come from the program table; ready only paces the driver.
    task automatic load_words(input int n, input bit with_last, input bit toggle);
        bit acc;
        int tries;
        for (int i = 0; i < n; i++) begin
            if (i < DEPTH) beat_q.push_back('{addr: 32'(i * 4), data: prog[i]});
            if (toggle && i > 0) begin
                word_valid = 1'b0;
                word_data  = 32'hDEADBEEF;
                word_last  = 1'b1;
                tick();
            end
            word_valid = 1'b1;
            word_data  = prog[i];
            word_last  = with_last && (i == n - 1);
            tries = 0;
            do begin
                @(negedge clk);
                acc = (word_ready === 1'b1);
                tick();
                tries++;
            end while (!acc && tries < 4);
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic wait_start0();
        int n = 0;
        while (start !== 1'b0) begin
            if (n == 20) begin
                $display("FAIL wait_start0: got start=%b expected 0 within 20 cycles", start);
                $fatal(1, "timeout");
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1) begin
            if (n == 100) begin
                $display("FAIL wait_done: got done=%b expected 1 within 100 cycles", done);
                $fatal(1, "timeout");
            end
            tick();
            n++;
        end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        load_req   = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        run_cycles = '0;
        halt       = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        ctl_q.push_back(CK_RESET);
        tick();

        // Three-word program, budget 10; a stray load_req mid-run is ignored.
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113; prog[2] = 32'h002081B3;
        done_q.push_back('{cc: 16'd10, err: 1'b0, runlen: 10});
        start_load(16'd10);
        load_words(3, 1'b1, 1'b0);
        wait_start0();
        repeat (3) tick();
        load_req   = 1'b1;
        run_cycles = 16'd3;
        tick();
        load_req   = 1'b0;
        wait_done();

        // Reload from DONE, gapped valid, unbounded run halted on cycle 7.
        prog[0] = 32'h00108093; prog[1] = 32'h00210113; prog[2] = 32'h00318193; prog[3] = 32'h00420213;
        done_q.push_back('{cc: 16'd7, err: 1'b0, runlen: 7});
        start_load(16'd0);
        load_words(4, 1'b1, 1'b1);
        wait_start0();
        repeat (6) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done();

        // Overflow: six words without last into a 4-word memory.
        for (int i = 0; i < 6; i++) prog[i] = 32'h11111111 * 32'(i + 1);
        done_q.push_back('{cc: 16'd0, err: 1'b1, runlen: 0});
        start_load(16'd5);
        load_words(6, 1'b0, 1'b0);
        wait_done();

        // Reset during run cycle 3 aborts to IDLE.
        prog[0] = 32'h00000013; prog[1] = 32'h00100073;
        start_load(16'd0);
        load_words(2, 1'b1, 1'b0);
        wait_start0();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctl_q.push_back(CK_RESET);
        repeat (2) tick();

        // One-word program, budget 2 with halt on the same final cycle.
        prog[0] = 32'hCAFE0013;
        done_q.push_back('{cc: 16'd2, err: 1'b0, runlen: 2});
        start_load(16'd2);
        load_words(1, 1'b1, 1'b0);
        wait_start0();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done();

        repeat (2) tick();
        finish_req = 1'b1;
    end

endmodule
